board_io_adapter: RTL and testbench

BOARD_IO_ADAPTER -- requirements
Module: board_io_adapter

---
 rtl/board_io_adapter.sv | 273 +++++++++++++++++++++++++++
 tb/tb_board_io_adapter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_adapter.sv
// board_io_adapter: glue between raw development-board I/O and a user design.
//   - switches: 2-flop synchroniser, per-bit debounce counter, rising pulse
//   - 7-segment: time-multiplexed scan of DIGITS hex digits, active-low drive
//   - VGA: colour depth expansion by MSB-first bit replication, syncs aligned
//   - tick_en: divided clock enable for the user design
// All state is on the rising edge of clk; rst_n is synchronous, active-low.
module board_io_adapter #(
  parameter int SW_W         = 16,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_CYC     = 100000,
  parameter int COLOR_IN_W   = 2,
  parameter int COLOR_OUT_W  = 4,
  parameter int CLK_DIV      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // switches
  input  logic [SW_W-1:0]        sw_raw,
  output logic [SW_W-1:0]        sw_clean,
  output logic [SW_W-1:0]        sw_rise,
  // 7-segment display
  input  logic [4*DIGITS-1:0]    disp_value,
  input  logic [DIGITS-1:0]      disp_dp,
  input  logic [DIGITS-1:0]      disp_blank,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [DIGITS-1:0]      an,
  // video
  input  logic [COLOR_IN_W-1:0]  r_in,
  input  logic [COLOR_IN_W-1:0]  g_in,
  input  logic [COLOR_IN_W-1:0]  b_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [COLOR_OUT_W-1:0] vga_r,
  output logic [COLOR_OUT_W-1:0] vga_g,
  output logic [COLOR_OUT_W-1:0] vga_b,
  output logic                   hsync_out,
  output logic                   vsync_out,
  // clock enable
  output logic                   tick_en
);

  // ---------------------------------------------------------------------
  // Counter widths. Each counter only ever holds 0..N-1, so clog2(N) bits
  // suffice; a floor of 1 bit keeps N=1 configurations legal.
  // ---------------------------------------------------------------------
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SC_W  = (SCAN_CYC > 1)     ? $clog2(SCAN_CYC)     : 1;
  localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int TK_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [TK_W-1:0]  TK_LAST  = TK_W'(CLK_DIV - 1);

  // =====================================================================
  // Switch path
  // =====================================================================
  logic [SW_W-1:0] sync1_q;
  logic [SW_W-1:0] sync2_q;
  logic [SW_W-1:0] clean_q;
  logic [SW_W-1:0] clean_d;
  logic [SW_W-1:0] rise_q;
  logic [SW_W-1:0] rise_d;
  logic [DB_W-1:0] db_cnt_q [SW_W];
  logic [DB_W-1:0] db_cnt_d [SW_W];

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive cycles where the synced bit differs
  // from the accepted level; accept the change on the DEBOUNCE_CYC-th one.
  // Any agreeing cycle (i.e. a glitch ending) restarts the count from zero.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < SW_W; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          // counter stays cleared so the next change starts fresh
          clean_d[i] = ~clean_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    // pulse coincides with the first cycle the new high level is visible
    rise_d = clean_d & ~clean_q;
  end

  // Debounce state registers: accepted level, rising pulse and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_q <= '0;
      rise_q  <= '0;
      for (int i = 0; i < SW_W; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      rise_q  <= rise_d;
      for (int i = 0; i < SW_W; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;

  // =====================================================================
  // 7-segment scan
  // =====================================================================
  logic [SC_W-1:0]   scan_q;
  logic [SC_W-1:0]   scan_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [3:0]        nib;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;

  // Scan timer and digit index: the index advances once per SCAN_CYC cycles
  // and wraps after the last digit (stays 0 when DIGITS is 1).
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SC_LAST) begin
      scan_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Decode the selected digit into active-low segment, point and anode drive.
  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  always_comb begin
    nib  = disp_value[{idx_q, 2'b00} +: 4];
    dp_d = ~disp_dp[idx_q];
    an_d = '1;
    if (!disp_blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
    case (nib)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  // Scan state and registered display drive; outputs idle dark in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= '1;
      dp_q   <= 1'b1;
      an_q   <= '1;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

  // =====================================================================
  // Video path
  // =====================================================================
  // Replicate the input MSB-first until the output is full, dropping any
  // leftover low bits. This maps full-scale in to full-scale out.
  function automatic logic [COLOR_OUT_W-1:0] expand(input logic [COLOR_IN_W-1:0] c);
    logic [COLOR_OUT_W-1:0] o;
    o = '0;
    for (int k = 0; k < COLOR_OUT_W; k++) begin
      o[COLOR_OUT_W-1-k] = c[COLOR_IN_W-1-(k % COLOR_IN_W)];
    end
    return o;
  endfunction

  logic [COLOR_OUT_W-1:0] vga_r_q;
  logic [COLOR_OUT_W-1:0] vga_g_q;
  logic [COLOR_OUT_W-1:0] vga_b_q;
  logic                   hsync_q;
  logic                   vsync_q;

  // Colours and syncs share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      vga_r_q <= expand(r_in);
      vga_g_q <= expand(g_in);
      vga_b_q <= expand(b_in);
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
    end
  end

  assign vga_r     = vga_r_q;
  assign vga_g     = vga_g_q;
  assign vga_b     = vga_b_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

  // =====================================================================
  // Clock enable
  // =====================================================================
  logic [TK_W-1:0] tick_cnt_q;
  logic [TK_W-1:0] tick_cnt_d;
  logic            tick_en_q;

  // Divider counter: 0..CLK_DIV-1, wrapping.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick_cnt_q == TK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // tick_en is registered alongside the counter so it is high exactly while
  // the counter sits at its terminal value, and low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_en_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_en_q  <= (tick_cnt_d == TK_LAST);
    end
  end

  assign tick_en = tick_en_q;

endmodule

// File: tb/tb_board_io_adapter.sv
// Bench for board_io_adapter with small parameters (debounce 4, scan 3,
// 4 digits, divide-by-2, 2 switches, 2->4 bit colour).
module tb_board_io_adapter;

  localparam int SW_W   = 2;
  localparam int DIGITS = 4;
  localparam int DEB    = 4;
  localparam int SCAN   = 3;
  localparam int CIN    = 2;
  localparam int COUT   = 4;
  localparam int CDIV   = 2;
  localparam int HIST   = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SW_W-1:0]     sw_raw = '0;
  logic [SW_W-1:0]     sw_clean;
  logic [SW_W-1:0]     sw_rise;
  logic [4*DIGITS-1:0] disp_value = '0;
  logic [DIGITS-1:0]   disp_dp = '0;
  logic [DIGITS-1:0]   disp_blank = '0;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic [CIN-1:0]      r_in = '0;
  logic [CIN-1:0]      g_in = '0;
  logic [CIN-1:0]      b_in = '0;
  logic                hsync_in = 1'b0;
  logic                vsync_in = 1'b0;
  logic [COUT-1:0]     vga_r;
  logic [COUT-1:0]     vga_g;
  logic [COUT-1:0]     vga_b;
  logic                hsync_out;
  logic                vsync_out;
  logic                tick_en;

  always #5 clk = ~clk;

  board_io_adapter #(
    .SW_W(SW_W), .DIGITS(DIGITS), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN),
    .COLOR_IN_W(CIN), .COLOR_OUT_W(COUT), .CLK_DIV(CDIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_raw(sw_raw), .sw_clean(sw_clean), .sw_rise(sw_rise),
    .disp_value(disp_value), .disp_dp(disp_dp), .disp_blank(disp_blank),
    .seg(seg), .dp(dp), .an(an),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .tick_en(tick_en)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Segments lit for each hex digit, by letter.
  string lit_segs [0:15] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                             "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                             "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] p;
    string s;
    p = 7'h7F;
    s = lit_segs[v];
    for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
    return p;
  endfunction

  int              k = 0;             // edges since reset release
  logic [SW_W-1:0] raw_hist [0:HIST-1];
  logic [SW_W-1:0] syn_hist [0:HIST-1];
  int              last_tog [SW_W];
  logic [SW_W-1:0] m_clean = '0;
  logic [SW_W-1:0] e_rise = '0;
  logic [6:0]      e_seg = 7'h7F;
  logic            e_dp = 1'b1;
  logic [DIGITS-1:0] e_an = '1;
  logic [COUT-1:0] e_r = '0;
  logic [COUT-1:0] e_g = '0;
  logic [COUT-1:0] e_b = '0;
  logic            e_hs = 1'b0;
  logic            e_vs = 1'b0;
  logic            e_tick = 1'b0;

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    logic [SW_W-1:0] prev;
    logic [DIGITS-1:0] one;
    int idx;
    bit all_diff;
    if (!rst_n) begin
      k = 0;
      m_clean = '0;
      e_rise = '0;
      for (int i = 0; i < SW_W; i++) last_tog[i] = 0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
      e_r = '0; e_g = '0; e_b = '0; e_hs = 1'b0; e_vs = 1'b0;
      e_tick = 1'b0;
    end else begin
      k++;
      raw_hist[k] = sw_raw;
      // value seen by the debouncer at this edge: raw from two edges back
      syn_hist[k] = (k >= 3) ? raw_hist[k-2] : '0;
      prev = m_clean;
      for (int i = 0; i < SW_W; i++) begin
        if (k - last_tog[i] >= DEB) begin
          all_diff = 1'b1;
          for (int j = k - DEB + 1; j <= k; j++)
            if (syn_hist[j][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_clean[i] = ~m_clean[i];
            last_tog[i] = k;
          end
        end
      end
      e_rise = m_clean & ~prev;
      idx = ((k - 1) / SCAN) % DIGITS;
      e_seg = seg_of(disp_value[idx*4 +: 4]);
      e_dp = ~disp_dp[idx];
      one = 1;
      e_an = disp_blank[idx] ? '1 : ~(one << idx);
      e_r = COUT'(int'(r_in) * ((2**COUT - 1) / (2**CIN - 1)));
      e_g = COUT'(int'(g_in) * ((2**COUT - 1) / (2**CIN - 1)));
      e_b = COUT'(int'(b_in) * ((2**COUT - 1) / (2**CIN - 1)));
      e_hs = hsync_in;
      e_vs = vsync_in;
      e_tick = ((k % CDIV) == CDIV - 1);
    end
  endtask

  task automatic compare_all();
    check("sw_clean", 32'(sw_clean), 32'(m_clean));
    check("sw_rise", 32'(sw_rise), 32'(e_rise));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("vga_r", 32'(vga_r), 32'(e_r));
    check("vga_g", 32'(vga_g), 32'(e_g));
    check("vga_b", 32'(vga_b), 32'(e_b));
    check("syncs", 32'({hsync_out, vsync_out}), 32'({e_hs, e_vs}));
    check("tick_en", 32'(tick_en), 32'(e_tick));
  endtask

  // One clock: edge, model update, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0] blank;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } scan_vec_t;

  scan_vec_t tbl [9];

  initial begin
    // digit0=1, digit1=0, digit2=8, digit3=F; point on digit 0
    tbl[0] = '{4'b0000, 4'b1110, 7'b1111001, 1'b0};
    tbl[1] = '{4'b0000, 4'b1101, 7'b1000000, 1'b1};
    tbl[2] = '{4'b0000, 4'b1011, 7'b0000000, 1'b1};
    tbl[3] = '{4'b0000, 4'b0111, 7'b0001110, 1'b1};
    tbl[4] = '{4'b0010, 4'b1110, 7'b1111001, 1'b0};
    tbl[5] = '{4'b0010, 4'b1111, 7'b1000000, 1'b1};
    tbl[6] = '{4'b0010, 4'b1011, 7'b0000000, 1'b1};
    tbl[7] = '{4'b0010, 4'b0111, 7'b0001110, 1'b1};
    tbl[8] = '{4'b0000, 4'b1110, 7'b1111001, 1'b0};

    // reset
    rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_tick", 32'(tick_en), 32'h0);
    check("rst_vga_r", 32'(vga_r), 32'h0);

    // scan sequence, table-driven, 3 cycles per digit slot
    disp_value = 16'hF801;
    disp_dp = 4'b0001;
    disp_blank = 4'b0000;
    rst_n = 1'b1;
    for (int s = 0; s < 9; s++) begin
      disp_blank = tbl[s].blank;
      for (int c = 0; c < SCAN; c++) begin
        cycle();
        check("scan_an", 32'(an), 32'(tbl[s].exp_an));
        check("scan_seg", 32'(seg), 32'(tbl[s].exp_seg));
        check("scan_dp", 32'(dp), 32'(tbl[s].exp_dp));
      end
    end
    disp_blank = 4'b0000;

    // debounce of bit 0: accepted 2 sync + 4 count edges later
    sw_raw = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      check("deb_clean0", 32'(sw_clean[0]), 32'(c >= 6));
      check("deb_rise0", 32'(sw_rise[0]), 32'(c == 6));
    end

    // 3-cycle glitch on bit 1 must be rejected
    sw_raw = 2'b11;
    repeat (3) cycle();
    sw_raw = 2'b01;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("glitch_clean1", 32'(sw_clean[1]), 32'h0);
    end

    // release bit 0: falls after 6 edges, no rising pulse
    sw_raw = 2'b00;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      check("fall_clean0", 32'(sw_clean[0]), 32'(c < 6));
      check("fall_rise0", 32'(sw_rise[0]), 32'h0);
    end

    // video: one cycle latency, all channels aligned
    r_in = 2'b01; g_in = 2'b10; b_in = 2'b11; hsync_in = 1'b1; vsync_in = 1'b0;
    cycle();
    check("vid_r", 32'(vga_r), 32'h5);
    check("vid_g", 32'(vga_g), 32'hA);
    check("vid_b", 32'(vga_b), 32'hF);
    check("vid_hs", 32'(hsync_out), 32'h1);
    r_in = 2'b00; g_in = 2'b00; b_in = 2'b00; hsync_in = 1'b0;
    cycle();
    check("vid_r_next", 32'(vga_r), 32'h0);
    check("vid_hs_next", 32'(hsync_out), 32'h0);

    // reset mid-debounce of bit 1, then debounce restarts from zero
    sw_raw = 2'b10;
    repeat (4) cycle();
    rst_n = 1'b0;
    cycle();
    check("midrst_clean", 32'(sw_clean), 32'h0);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_tick", 32'(tick_en), 32'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      check("restart_clean1", 32'(sw_clean[1]), 32'(c == 6));
      check("restart_tick", 32'(tick_en), 32'((c % 2) == 1));
      if (c == 1) check("restart_an", 32'(an), 32'hE);
    end
    sw_raw = 2'b00;
    repeat (8) cycle();

    // randomized run against the model, with occasional resets
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0) sw_raw = SW_W'($urandom_range(0, 3));
      disp_value = 16'($urandom_range(0, 65535));
      disp_dp = 4'($urandom_range(0, 15));
      disp_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      r_in = 2'($urandom_range(0, 3));
      g_in = 2'($urandom_range(0, 3));
      b_in = 2'($urandom_range(0, 3));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
